// File: rtl/fet_seg_gate_sequencer_if.sv
// ---------------------------------------------------------------------------
// fet_seg_gate_sequencer_if
// Bundles the control inputs and the gate/status outputs of the segmented
// FET gate sequencer.
//   master : loop/PWM side. Drives enable, pwm_in, oc_trip, seg_mask and
//            clr_latch. Observes gate_en, on_state, fault, fault_cnt and
//            latchoff.
//   slave  : the sequencer itself (opposite directions).
// ---------------------------------------------------------------------------
interface fet_seg_gate_sequencer_if #(
  parameter int N_SEG = 4
);
  logic             enable;
  logic             pwm_in;
  logic             oc_trip;
  logic [N_SEG-1:0] seg_mask;
  logic             clr_latch;
  logic [N_SEG-1:0] gate_en;
  logic             on_state;
  logic             fault;
  logic [3:0]       fault_cnt;
  logic             latchoff;

  modport master (
    output enable, pwm_in, oc_trip, seg_mask, clr_latch,
    input  gate_en, on_state, fault, fault_cnt, latchoff
  );

  modport slave (
    input  enable, pwm_in, oc_trip, seg_mask, clr_latch,
    output gate_en, on_state, fault, fault_cnt, latchoff
  );
endinterface

// File: rtl/fet_seg_gate_sequencer.sv
// ---------------------------------------------------------------------------
// fet_seg_gate_sequencer
// Gate-enable sequencer for a segmented power NMOS with replica current sense.
// Segments permitted by seg_mask turn on one at a time, lowest index first,
// STAGGER cycles apart. The replica overcurrent comparator is blanked for
// BLANK cycles after turn-on. An accepted trip drops every segment, pulses
// fault, cools down for RETRY cycles and then re-arms; MAX_FAULTS consecutive
// trips latch the block off until clr_latch.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fet_seg_gate_sequencer_if
//              (enable, pwm_in, oc_trip, seg_mask, clr_latch in;
//               gate_en, on_state, fault, fault_cnt, latchoff out, all
//               registered)
// ---------------------------------------------------------------------------
module fet_seg_gate_sequencer #(
  parameter int N_SEG      = 4,
  parameter int STAGGER    = 2,
  parameter int BLANK      = 8,
  parameter int RETRY      = 64,
  parameter int MAX_FAULTS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  fet_seg_gate_sequencer_if.slave   bus
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_COOL = 2'd3;

  localparam int BW = $clog2(BLANK + 1);
  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int RW = (RETRY > 1) ? $clog2(RETRY) : 1;

  localparam logic [BW-1:0] BLANK_END  = BW'(BLANK);
  localparam logic [SW-1:0] STAG_LAST  = SW'(STAGGER - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY - 1);
  localparam logic [3:0]    MAX_CNT    = 4'(MAX_FAULTS);

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [N_SEG-1:0] lowest_bit(input logic [N_SEG-1:0] v);
    lowest_bit = v & (~v + N_SEG'(1));
  endfunction

  // Fault count increment that holds at MAX_FAULTS.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    sat_inc = (c >= MAX_CNT) ? c : c + 4'd1;
  endfunction

  logic [1:0]       state;
  logic [N_SEG-1:0] mask_q;
  logic [N_SEG-1:0] gate_en;
  logic             on_state;
  logic             fault;
  logic [3:0]       fault_cnt;
  logic             latchoff;
  logic [BW-1:0]    blank_cnt;
  logic [SW-1:0]    stag_cnt;
  logic [RW-1:0]    retry_cnt;

  logic [N_SEG-1:0] first_bit;
  logic [N_SEG-1:0] step_bits;
  logic [3:0]       cnt_next;
  logic             start;
  logic             oc_accept;

  // Masked-off indices cost nothing: the next step jumps straight to the
  // lowest still-off bit of the captured mask.
  assign first_bit = lowest_bit(bus.seg_mask);
  assign step_bits = gate_en | lowest_bit(mask_q & ~gate_en);
  assign cnt_next  = sat_inc(fault_cnt);
  assign start     = bus.enable & bus.pwm_in & ~latchoff & (|bus.seg_mask);
  // blank_cnt saturates at BLANK, reached BLANK edges after turn-on, so the
  // trip is honoured from the value sampled after edge T+BLANK.
  assign oc_accept = bus.oc_trip & (blank_cnt == BLANK_END);

  // ---- registered stage: captured mask (data, no reset) ----
  always_ff @(posedge clk) begin
    if (state == ST_OFF && start) begin
      mask_q <= bus.seg_mask;
    end
  end

  // ---- registered stage: control state and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      gate_en   <= '0;
      on_state  <= 1'b0;
      fault     <= 1'b0;
      fault_cnt <= 4'd0;
      latchoff  <= 1'b0;
      blank_cnt <= '0;
      stag_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      fault <= 1'b0;
      // Later assignments on a fault edge override this clear.
      if (bus.clr_latch) begin
        fault_cnt <= 4'd0;
        latchoff  <= 1'b0;
      end
      case (state)
        ST_OFF: begin
          if (start) begin
            gate_en   <= first_bit;
            blank_cnt <= '0;
            stag_cnt  <= '0;
            if (first_bit == bus.seg_mask) begin
              state    <= ST_ON;
              on_state <= 1'b1;
            end else begin
              state <= ST_RAMP;
            end
          end
        end
        ST_RAMP, ST_ON: begin
          if (blank_cnt != BLANK_END) begin
            blank_cnt <= blank_cnt + BW'(1);
          end
          if (oc_accept) begin
            gate_en   <= '0;
            on_state  <= 1'b0;
            fault     <= 1'b1;
            fault_cnt <= cnt_next;
            latchoff  <= (cnt_next == MAX_CNT);
            retry_cnt <= '0;
            state     <= ST_COOL;
          end else if (!bus.enable || !bus.pwm_in) begin
            gate_en  <= '0;
            on_state <= 1'b0;
            state    <= ST_OFF;
            // A completed turn-on ends the consecutive-fault run.
            if (state == ST_ON) begin
              fault_cnt <= 4'd0;
            end
          end else if (state == ST_RAMP) begin
            if (stag_cnt == STAG_LAST) begin
              stag_cnt <= '0;
              gate_en  <= step_bits;
              if (step_bits == mask_q) begin
                state    <= ST_ON;
                on_state <= 1'b1;
              end
            end else begin
              stag_cnt <= stag_cnt + SW'(1);
            end
          end
        end
        default: begin
          if (retry_cnt == RETRY_LAST) begin
            state <= ST_OFF;
          end else begin
            retry_cnt <= retry_cnt + RW'(1);
          end
        end
      endcase
    end
  end

  assign bus.gate_en   = gate_en;
  assign bus.on_state  = on_state;
  assign bus.fault     = fault;
  assign bus.fault_cnt = fault_cnt;
  assign bus.latchoff  = latchoff;

endmodule

// File: tb/tb_fet_seg_gate_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fet_seg_gate_sequencer
// Bench for fet_seg_gate_sequencer with default parameters. The expected
// behaviour comes from a timestamp model: a ramp remembers its start edge and
// mask, segment of rank r is on once r*STAGGER edges have elapsed, a trip is
// honoured once more than BLANK edges have elapsed, and a cooldown ends
// RETRY edges after the fault edge.
// ---------------------------------------------------------------------------
module tb_fet_seg_gate_sequencer;

  localparam int N_SEG      = 4;
  localparam int STAGGER    = 2;
  localparam int BLANK      = 8;
  localparam int RETRY      = 64;
  localparam int MAX_FAULTS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             d_rst  = 1'b1;
  logic             d_en   = 1'b0;
  logic             d_pwm  = 1'b0;
  logic             d_oc   = 1'b0;
  logic             d_clr  = 1'b0;
  logic [N_SEG-1:0] d_mask = '0;

  fet_seg_gate_sequencer_if #(.N_SEG(N_SEG)) bus ();

  assign rst           = d_rst;
  assign bus.enable    = d_en;
  assign bus.pwm_in    = d_pwm;
  assign bus.oc_trip   = d_oc;
  assign bus.clr_latch = d_clr;
  assign bus.seg_mask  = d_mask;

  fet_seg_gate_sequencer #(
    .N_SEG(N_SEG), .STAGGER(STAGGER), .BLANK(BLANK),
    .RETRY(RETRY), .MAX_FAULTS(MAX_FAULTS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int n      = 0;

  // Reference model state
  bit               m_active = 0;
  bit               m_cool   = 0;
  int               m_t0     = 0;
  int               m_tf     = 0;
  logic [N_SEG-1:0] m_mq     = '0;
  logic [3:0]       m_cnt    = 4'd0;
  logic             m_lo     = 1'b0;
  logic             m_fault  = 1'b0;
  logic [N_SEG-1:0] m_gate   = '0;
  logic             m_on     = 1'b0;

  function automatic logic [N_SEG-1:0] ramp_bits(input logic [N_SEG-1:0] mq, input int elapsed);
    int r;
    ramp_bits = '0;
    r = 0;
    for (int i = 0; i < N_SEG; i++) begin
      if (mq[i]) begin
        if (r * STAGGER <= elapsed) ramp_bits[i] = 1'b1;
        r++;
      end
    end
  endfunction

  task automatic model_edge();
    logic [3:0] cnt_pre;
    logic       lo_pre;
    bit         was_on;
    cnt_pre = m_cnt;
    lo_pre  = m_lo;
    m_fault = 1'b0;
    if (d_rst) begin
      m_active = 0; m_cool = 0; m_cnt = 4'd0; m_lo = 1'b0;
    end else begin
      was_on = m_active && (ramp_bits(m_mq, n - 1 - m_t0) == m_mq);
      if (d_clr) begin m_cnt = 4'd0; m_lo = 1'b0; end
      if (m_active) begin
        if (d_oc && (n - 1 - m_t0) >= BLANK) begin
          m_active = 0; m_cool = 1; m_tf = n; m_fault = 1'b1;
          m_cnt = (cnt_pre < 4'(MAX_FAULTS)) ? cnt_pre + 4'd1 : cnt_pre;
          m_lo  = (m_cnt == 4'(MAX_FAULTS));
        end else if (!d_en || !d_pwm) begin
          m_active = 0;
          if (was_on) m_cnt = 4'd0;
        end
      end else if (m_cool) begin
        if (n - m_tf >= RETRY) m_cool = 0;
      end else if (d_en && d_pwm && !lo_pre && d_mask != '0) begin
        m_active = 1; m_t0 = n; m_mq = d_mask;
      end
    end
    m_gate = m_active ? ramp_bits(m_mq, n - m_t0) : '0;
    m_on   = m_active && (m_gate == m_mq);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", name, n, act, exp);
    end
  endtask

  // One clock: inputs are already set; model steps at the edge, outputs are
  // compared at the following negedge.
  task automatic tick();
    @(posedge clk);
    n++;
    model_edge();
    @(negedge clk);
    chk("model_gate_en",   32'(bus.gate_en),   32'(m_gate));
    chk("model_on_state",  32'(bus.on_state),  32'(m_on));
    chk("model_fault",     32'(bus.fault),     32'(m_fault));
    chk("model_fault_cnt", 32'(bus.fault_cnt), 32'(m_cnt));
    chk("model_latchoff",  32'(bus.latchoff),  32'(m_lo));
  endtask

  typedef struct {
    logic             rst, en, pwm, oc, clr;
    logic [N_SEG-1:0] mask;
    logic [N_SEG-1:0] gate;
    logic             on, fault;
    logic [3:0]       cnt;
    logic             lo;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic r, input logic e, input logic p, input logic o, input logic c,
                      input logic [N_SEG-1:0] m, input logic [N_SEG-1:0] g, input logic on,
                      input logic f, input logic [3:0] cn, input logic lo);
    vec_t v;
    v.rst = r; v.en = e; v.pwm = p; v.oc = o; v.clr = c; v.mask = m;
    v.gate = g; v.on = on; v.fault = f; v.cnt = cn; v.lo = lo;
    tbl.push_back(v);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout edge=%0d", n);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, f0;

    //    rst en pwm oc clr mask   gate  on f cnt lo
    addv(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);  // reset
    addv(0, 0, 1, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);  // disabled
    addv(0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);  // empty mask
    addv(0, 1, 1, 0, 0, 4'hF, 4'h1, 0, 0, 0, 0);  // T
    addv(0, 1, 1, 0, 0, 4'hF, 4'h1, 0, 0, 0, 0);
    addv(0, 1, 1, 0, 0, 4'hF, 4'h3, 0, 0, 0, 0);  // T+2
    addv(0, 1, 1, 0, 0, 4'hF, 4'h3, 0, 0, 0, 0);
    addv(0, 1, 1, 0, 0, 4'hF, 4'h7, 0, 0, 0, 0);  // T+4
    addv(0, 1, 1, 0, 0, 4'hF, 4'h7, 0, 0, 0, 0);
    addv(0, 1, 1, 0, 0, 4'hF, 4'hF, 1, 0, 0, 0);  // T+6
    addv(0, 1, 1, 0, 0, 4'hF, 4'hF, 1, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);  // pwm off
    addv(0, 1, 1, 0, 0, 4'hA, 4'h2, 0, 0, 0, 0);  // skip ramp T
    addv(0, 1, 1, 0, 0, 4'hF, 4'h2, 0, 0, 0, 0);  // mask change ignored
    addv(0, 1, 1, 0, 0, 4'hF, 4'hA, 1, 0, 0, 0);  // T+2 on
    addv(0, 1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
    addv(0, 1, 1, 0, 0, 4'h4, 4'h4, 1, 0, 0, 0);  // single segment
    addv(0, 0, 1, 0, 0, 4'h4, 4'h0, 0, 0, 0, 0);  // enable drop

    for (int i = 0; i < tbl.size(); i++) begin
      d_rst = tbl[i].rst; d_en = tbl[i].en; d_pwm = tbl[i].pwm;
      d_oc = tbl[i].oc; d_clr = tbl[i].clr; d_mask = tbl[i].mask;
      tick();
      chk("tbl_gate_en",   32'(bus.gate_en),   32'(tbl[i].gate));
      chk("tbl_on_state",  32'(bus.on_state),  32'(tbl[i].on));
      chk("tbl_fault",     32'(bus.fault),     32'(tbl[i].fault));
      chk("tbl_fault_cnt", 32'(bus.fault_cnt), 32'(tbl[i].cnt));
      chk("tbl_latchoff",  32'(bus.latchoff),  32'(tbl[i].lo));
    end

    // Blanking: trip over cycles T..T+7 is ignored
    d_en = 1; d_pwm = 1; d_mask = 4'hF; d_oc = 0;
    tick(); t0 = n;
    d_oc = 1;
    repeat (8) tick();
    chk("blank_ignored_gate", 32'(bus.gate_en), 32'h0F);
    chk("blank_ignored_cnt",  32'(bus.fault_cnt), 32'd0);
    d_oc = 0; tick();
    chk("blank_ignored_fault", 32'(bus.fault), 32'd0);
    d_pwm = 0; tick();

    // Held trip: fault at T+9, re-arm after RETRY
    d_pwm = 1; tick(); t0 = n;
    d_oc = 1;
    repeat (8) tick();
    chk("pre_blank_fault", 32'(bus.fault), 32'd0);
    tick();
    chk("trip_fault_t9", 32'(bus.fault), 32'd1);
    chk("trip_gate_t9",  32'(bus.gate_en), 32'd0);
    chk("trip_cnt_t9",   32'(bus.fault_cnt), 32'd1);
    f0 = n;
    d_oc = 0;
    tick();
    chk("fault_one_cycle", 32'(bus.fault), 32'd0);
    while (n < f0 + RETRY) tick();
    chk("cool_gate_off", 32'(bus.gate_en), 32'd0);
    tick();
    chk("rearm_gate", 32'(bus.gate_en), 32'h1);

    // Latch-off after MAX_FAULTS consecutive trips, trip held high
    d_oc = 1;
    repeat (9) tick();
    chk("fault2_cnt", 32'(bus.fault_cnt), 32'd2);
    chk("fault2_lo",  32'(bus.latchoff), 32'd0);
    repeat (RETRY + 10) tick();
    chk("fault3_pulse", 32'(bus.fault), 32'd1);
    chk("fault3_cnt",   32'(bus.fault_cnt), 32'd3);
    chk("fault3_lo",    32'(bus.latchoff), 32'd1);
    f0 = n;
    while (n < f0 + RETRY + 5) tick();
    chk("latched_gate", 32'(bus.gate_en), 32'd0);
    chk("latched_lo",   32'(bus.latchoff), 32'd1);
    d_oc = 0; d_clr = 1;
    tick();
    chk("clr_cnt",  32'(bus.fault_cnt), 32'd0);
    chk("clr_lo",   32'(bus.latchoff), 32'd0);
    chk("clr_gate", 32'(bus.gate_en), 32'd0);
    d_clr = 0;
    tick();
    chk("clr_restart", 32'(bus.gate_en), 32'h1);

    // Normal off from ON clears the fault count
    d_oc = 1;
    repeat (9) tick();
    d_oc = 0;
    repeat (RETRY + 1) tick();
    repeat (6) tick();
    chk("on_state_reached", 32'(bus.on_state), 32'd1);
    chk("on_cnt_kept",      32'(bus.fault_cnt), 32'd1);
    d_pwm = 0; tick();
    chk("off_gate", 32'(bus.gate_en), 32'd0);
    chk("off_cnt",  32'(bus.fault_cnt), 32'd0);

    // Trip and pwm fall on the same edge: trip wins
    d_pwm = 1; tick();
    repeat (10) tick();
    d_pwm = 0; d_oc = 1; tick();
    chk("prio_fault", 32'(bus.fault), 32'd1);
    chk("prio_cnt",   32'(bus.fault_cnt), 32'd1);
    chk("prio_gate",  32'(bus.gate_en), 32'd0);
    f0 = n;
    d_oc = 0; d_pwm = 1; tick();
    chk("prio_cool_gate", 32'(bus.gate_en), 32'd0);
    while (n < f0 + RETRY) tick();
    chk("prio_cool_end_gate", 32'(bus.gate_en), 32'd0);
    tick();
    chk("prio_rearm", 32'(bus.gate_en), 32'h1);

    // Reset mid-ramp
    d_pwm = 0; tick();
    d_pwm = 1; tick();
    repeat (2) tick();
    chk("rst_pre_gate", 32'(bus.gate_en), 32'h3);
    d_rst = 1; tick();
    chk("rst_gate",  32'(bus.gate_en), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_cnt",   32'(bus.fault_cnt), 32'd0);
    chk("rst_on",    32'(bus.on_state), 32'd0);
    d_rst = 0;

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      d_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) d_pwm = ~d_pwm;
      d_en  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) d_oc = ~d_oc;
      d_clr = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 29) == 0) d_mask = N_SEG'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
